// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the RV32I multi-cycle core.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned SEL_W    = 2;

  // Main control FSM states; encodings are visible on the debug port.
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8
  } state_e;

  // Supported major opcodes
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;

  // ALUOp handed to the ALU control decoder
  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'b01;
  localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b10;

  // ALU operand B select
  localparam logic [SEL_W-1:0] SRC_B_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_IMM   = 2'b10;

  // Complete set of datapath control lines driven by the FSM
  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic             pc_source;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic             reg_write;
    logic             mem_to_reg;
    logic             instr_done;
    logic             illegal_instr;
  } ctrl_t;

  // True for opcodes that go through the address-calculation step
  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control decoder for the multi-cycle main FSM.
module mc_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output ctrl_t               ctrl
);

  // Moore decode with ready/zero-gated terms; unused encodings drive all zeros
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_a = SRC_A_OLD_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        if (!is_mem_op(opcode) && opcode != OPC_OP && opcode != OPC_BRANCH) begin
          ctrl.illegal_instr = 1'b1;
          ctrl.instr_done    = 1'b1;
        end
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_EXECUTE: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_source  = 1'b1;
        ctrl.pc_write   = zero;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: state register, next-state logic and reset gating.
module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_source,
  output logic [SEL_W-1:0]    alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [SEL_W-1:0]    alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                instr_done,
  output logic                illegal_instr,
  output logic [STATE_W-1:0]  state
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_g;

  // State register; reset parks the FSM in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next-state sequencing through the shared datapath steps
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (is_mem_op(opcode))        state_d = ST_MEM_ADDR;
        else if (opcode == OPC_OP)     state_d = ST_EXECUTE;
        else if (opcode == OPC_BRANCH) state_d = ST_BRANCH;
        else                           state_d = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        if (opcode == OPC_LOAD)       state_d = ST_MEM_READ;
        else if (opcode == OPC_STORE) state_d = ST_MEM_WRITE;
        else                          state_d = ST_FETCH;
      end
      ST_MEM_READ:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_EXECUTE:   state_d = ST_ALU_WB;
      ST_ALU_WB:    state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Hold every control line low while reset is asserted
  always_comb begin
    ctrl_g = '0;
    if (rst_n) ctrl_g = ctrl;
  end

  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign i_or_d        = ctrl_g.i_or_d;
  assign ir_write      = ctrl_g.ir_write;
  assign pc_write      = ctrl_g.pc_write;
  assign pc_source     = ctrl_g.pc_source;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign alu_op        = ctrl_g.alu_op;
  assign reg_write     = ctrl_g.reg_write;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign instr_done    = ctrl_g.instr_done;
  assign illegal_instr = ctrl_g.illegal_instr;
  assign state         = rst_n ? STATE_W'(state_q) : STATE_W'(ST_FETCH);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-stream bench for the multi-cycle main control FSM.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, instr_done, illegal_instr;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          st;
    logic        rdy;
    logic        z;
    logic [6:0]  opc;
    logic [15:0] outs;
  } step_t;

  step_t q[$];

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ILL = 4;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal_instr(illegal_instr),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control vector in a fixed field order
  function automatic logic [15:0] ov(input logic mr, input logic mw, input logic iod,
                                     input logic irw, input logic pcw, input logic pcs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] op, input logic rw, input logic m2r,
                                     input logic done, input logic ill);
    return {mr, mw, iod, irw, pcw, pcs, sa, sb, op, rw, m2r, done, ill};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
            alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done, illegal_instr};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] ropc();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic void push(input int st, input logic rdy, input logic z,
                               input logic [6:0] opc, input logic [15:0] o);
    step_t s;
    s.st = st; s.rdy = rdy; s.z = z; s.opc = opc; s.outs = o;
    q.push_back(s);
  endfunction

  // Expand one instruction into its expected cycle-by-cycle behaviour
  function automatic void add_instr(input int kind, input logic [6:0] opc,
                                    input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++)
      push(0, 1'b0, rbit(), ropc(), ov(1,0,0,0,0,0,2'b00,2'b01,2'b00,0,0,0,0));
    push(0, 1'b1, rbit(), ropc(), ov(1,0,0,1,1,0,2'b00,2'b01,2'b00,0,0,0,0));
    push(1, rbit(), rbit(), opc,
         ov(0,0,0,0,0,0,2'b10,2'b10,2'b00,0,0,kind == K_ILL,kind == K_ILL));
    case (kind)
      K_LW: begin
        push(2, rbit(), rbit(), opc, ov(0,0,0,0,0,0,2'b01,2'b10,2'b00,0,0,0,0));
        for (int i = 0; i < mw; i++)
          push(3, 1'b0, rbit(), opc, ov(1,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0));
        push(3, 1'b1, rbit(), opc, ov(1,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0));
        push(4, rbit(), rbit(), opc, ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1,1,0));
      end
      K_SW: begin
        push(2, rbit(), rbit(), opc, ov(0,0,0,0,0,0,2'b01,2'b10,2'b00,0,0,0,0));
        for (int i = 0; i < mw; i++)
          push(5, 1'b0, rbit(), opc, ov(0,1,1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0));
        push(5, 1'b1, rbit(), opc, ov(0,1,1,0,0,0,2'b00,2'b00,2'b00,0,0,1,0));
      end
      K_R: begin
        push(6, rbit(), rbit(), opc, ov(0,0,0,0,0,0,2'b01,2'b00,2'b10,0,0,0,0));
        push(7, rbit(), rbit(), opc, ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,1,0));
      end
      K_BEQ: push(8, rbit(), z, opc, ov(0,0,0,0,z,1,2'b01,2'b00,2'b01,0,0,1,0));
      default: ;
    endcase
  endfunction

  function automatic logic [6:0] illegal_opc();
    logic [6:0] r;
    do r = ropc();
    while (r == 7'b0000011 || r == 7'b0100011 || r == 7'b0110011 || r == 7'b1100011);
    return r;
  endfunction

  function automatic logic [6:0] kind_opc(input int kind);
    case (kind)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_BEQ:   return 7'b1100011;
      default: return illegal_opc();
    endcase
  endfunction

  // Drive each queued step just after a falling edge and check before the next rise
  task automatic run_steps();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.rdy;
      zero      = s.z;
      opcode    = s.opc;
      #1;
      check("state", 32'(state), 32'(s.st));
      check("ctrl", 32'(dut_vec()), 32'(s.outs));
      check("excl", 32'({mem_read & mem_write, pc_write & reg_write}), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = 7'b0110011;
    @(negedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    check("rst_hold_state", 32'(state), 32'd0);
    rst_n = 1'b1;

    // Directed instructions from the plan
    add_instr(K_R,   7'b0110011, 0, 0, 1'b0);
    add_instr(K_LW,  7'b0000011, 0, 2, 1'b0);
    add_instr(K_SW,  7'b0100011, 0, 0, 1'b0);
    add_instr(K_BEQ, 7'b1100011, 0, 0, 1'b1);
    add_instr(K_BEQ, 7'b1100011, 0, 0, 1'b0);
    add_instr(K_ILL, 7'b1111111, 0, 0, 1'b0);
    add_instr(K_LW,  7'b0000011, 2, 0, 1'b0);
    run_steps();

    // Store interrupted by reset while memory is stalled
    push(0, 1'b1, 1'b0, ropc(),     ov(1,0,0,1,1,0,2'b00,2'b01,2'b00,0,0,0,0));
    push(1, 1'b0, 1'b0, 7'b0100011, ov(0,0,0,0,0,0,2'b10,2'b10,2'b00,0,0,0,0));
    push(2, 1'b0, 1'b0, 7'b0100011, ov(0,0,0,0,0,0,2'b01,2'b10,2'b00,0,0,0,0));
    push(5, 1'b0, 1'b0, 7'b0100011, ov(0,1,1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0));
    run_steps();
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_ctrl", 32'(dut_vec()), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("midrst_ready_ctrl", 32'(dut_vec()), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    add_instr(K_SW, 7'b0100011, 1, 1, 1'b0);
    run_steps();

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 4);
      add_instr(kind, kind_opc(kind), $urandom_range(0, 3), $urandom_range(0, 3), rbit());
      run_steps();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
